bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one downstream bus between a fetch port and a load/store port.
// One transaction is outstanding at a time: grant in IDLE, present in REQ, collect the response in WAIT.
module bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                mem_req_valid,
  output logic                mem_req_ready,
  input  logic                mem_req_wr,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_resp_valid,
  output logic [DATA_W-1:0]   mem_resp_data,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic                bus_req_wr,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_resp_valid,
  input  logic [DATA_W-1:0]   bus_resp_data,
  output logic                grant_mem
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              state_q, state_d;
  // The current owner is also the last grant used for round-robin.
  logic                grant_mem_q, grant_mem_d;
  logic                req_wr_q, req_wr_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic [STRB_W-1:0]   req_wstrb_q, req_wstrb_d;
  logic                if_resp_valid_q, if_resp_valid_d;
  logic                mem_resp_valid_q, mem_resp_valid_d;
  logic [DATA_W-1:0]   if_resp_data_q, if_resp_data_d;
  logic [DATA_W-1:0]   mem_resp_data_q, mem_resp_data_d;
  logic                pick_mem;

  always_comb begin
    state_d          = state_q;
    grant_mem_d      = grant_mem_q;
    req_wr_d         = req_wr_q;
    req_addr_d       = req_addr_q;
    req_wdata_d      = req_wdata_q;
    req_wstrb_d      = req_wstrb_q;
    if_resp_valid_d  = 1'b0;
    mem_resp_valid_d = 1'b0;
    if_resp_data_d   = if_resp_data_q;
    mem_resp_data_d  = mem_resp_data_q;
    if_req_ready     = 1'b0;
    mem_req_ready    = 1'b0;
    bus_req_valid    = 1'b0;
    pick_mem = mem_req_valid && (!if_req_valid || !grant_mem_q);

    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (pick_mem) begin
            mem_req_ready = 1'b1;
            grant_mem_d   = 1'b1;
            req_wr_d      = mem_req_wr;
            req_addr_d    = mem_addr;
            req_wdata_d   = mem_wdata;
            req_wstrb_d   = mem_wstrb;
            state_d       = REQ;
          end else if (if_req_valid) begin
            if_req_ready = 1'b1;
            grant_mem_d  = 1'b0;
            req_wr_d     = 1'b0;
            req_addr_d   = if_addr;
            req_wdata_d  = '0;
            req_wstrb_d  = '0;
            state_d      = REQ;
          end
        end
        REQ: begin
          bus_req_valid = 1'b1;
          if (bus_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (bus_resp_valid) begin
            if (grant_mem_q) begin
              mem_resp_valid_d = 1'b1;
              mem_resp_data_d  = bus_resp_data;
            end else begin
              if_resp_valid_d = 1'b1;
              if_resp_data_d  = bus_resp_data;
            end
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      grant_mem_q      <= 1'b0;
      req_wr_q         <= 1'b0;
      req_addr_q       <= '0;
      req_wdata_q      <= '0;
      req_wstrb_q      <= '0;
      if_resp_valid_q  <= 1'b0;
      mem_resp_valid_q <= 1'b0;
      if_resp_data_q   <= '0;
      mem_resp_data_q  <= '0;
    end else begin
      state_q          <= state_d;
      grant_mem_q      <= grant_mem_d;
      req_wr_q         <= req_wr_d;
      req_addr_q       <= req_addr_d;
      req_wdata_q      <= req_wdata_d;
      req_wstrb_q      <= req_wstrb_d;
      if_resp_valid_q  <= if_resp_valid_d;
      mem_resp_valid_q <= mem_resp_valid_d;
      if_resp_data_q   <= if_resp_data_d;
      mem_resp_data_q  <= mem_resp_data_d;
    end
  end

  assign if_resp_valid  = if_resp_valid_q && !reset;
  assign mem_resp_valid = mem_resp_valid_q && !reset;
  assign if_resp_data   = if_resp_data_q;
  assign mem_resp_data  = mem_resp_data_q;
  assign bus_req_wr     = req_wr_q;
  assign bus_addr       = req_addr_q;
  assign bus_wdata      = req_wdata_q;
  assign bus_wstrb      = req_wstrb_q;
  assign grant_mem      = grant_mem_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: random requesters, downstream responder and resets,
// checked against a transaction-level model of ownership, round-robin and response routing.
module tb_bus_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_addr, if_resp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_wr, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_resp_data;
  logic [7:0]  mem_wstrb;
  logic        bus_req_valid, bus_req_ready, bus_req_wr, bus_resp_valid, grant_mem;
  logic [63:0] bus_addr, bus_wdata, bus_resp_data;
  logic [7:0]  bus_wstrb;

  bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_wr(bus_req_wr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .grant_mem(grant_mem)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int n_txn = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // requester-side stimulus state
  bit          if_pend, mem_pend, mem_w;
  logic [63:0] if_a, mem_a, mem_d;
  logic [7:0]  mem_s;
  // transaction-level model
  bit          m_busy, m_bus_acc, m_owner_mem, m_last_mem;
  bit          m_resp_due, m_resp_mem, m_resp_load;
  logic [63:0] m_if_data, m_mem_data;
  bit          x_wr;
  logic [63:0] x_addr, x_wdata;
  logic [7:0]  x_wstrb;
  int          resp_wait;
  bit          g_mem, g_if, exp_bv;

  task automatic model_reset();
    m_busy = 0; m_bus_acc = 0; m_owner_mem = 0; m_last_mem = 0;
    m_resp_due = 0; m_resp_mem = 0; m_resp_load = 0;
    m_if_data = '0; m_mem_data = '0; resp_wait = 0;
  endtask

  initial begin
    reset = 1'b1;
    if_req_valid = 0; mem_req_valid = 0; mem_req_wr = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    bus_req_ready = 0; bus_resp_valid = 0; bus_resp_data = '0;
    model_reset();
    // both requesters waiting as reset releases: the first contest must go to mem
    if_pend = 1; if_a = 64'h8000_0000;
    mem_pend = 1; mem_w = 1; mem_a = 64'h8000_1000; mem_d = 64'hDEAD_BEEF; mem_s = 8'h0F;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      reset = (cyc < 3) || ($urandom_range(0, 149) == 0);
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_a = {$urandom, $urandom};
      end
      if (!mem_pend && $urandom_range(0, 2) == 0) begin
        mem_pend = 1; mem_w = 1'($urandom_range(0, 1));
        mem_a = {$urandom, $urandom}; mem_d = {$urandom, $urandom}; mem_s = 8'($urandom);
      end
      if_req_valid = if_pend; if_addr = if_a;
      mem_req_valid = mem_pend; mem_req_wr = mem_w; mem_addr = mem_a;
      mem_wdata = mem_d; mem_wstrb = mem_s;
      bus_req_ready = ($urandom_range(0, 9) < 7);
      bus_resp_data = {$urandom, $urandom};
      if (m_busy && m_bus_acc) begin
        bus_resp_valid = (resp_wait == 0);
        if (resp_wait > 0) resp_wait--;
      end else begin
        // responses arriving with nothing in flight must be ignored
        bus_resp_valid = ($urandom_range(0, 9) == 0);
      end
      #1;

      g_mem  = !reset && !m_busy && mem_pend && (!if_pend || !m_last_mem);
      g_if   = !reset && !m_busy && if_pend && !g_mem;
      exp_bv = !reset && m_busy && !m_bus_acc;
      check_val("if_req_ready", 64'(if_req_ready), 64'(g_if));
      check_val("mem_req_ready", 64'(mem_req_ready), 64'(g_mem));
      check_val("bus_req_valid", 64'(bus_req_valid), 64'(exp_bv));
      if (exp_bv) begin
        check_val("bus_addr", bus_addr, x_addr);
        check_val("bus_req_wr", 64'(bus_req_wr), 64'(x_wr));
        check_val("bus_wstrb", 64'(bus_wstrb), 64'(x_wstrb));
        check_val("grant_mem", 64'(grant_mem), 64'(m_owner_mem));
        if (x_wr) check_val("bus_wdata", bus_wdata, x_wdata);
      end
      check_val("if_resp_valid", 64'(if_resp_valid), 64'(!reset && m_resp_due && !m_resp_mem));
      check_val("mem_resp_valid", 64'(mem_resp_valid), 64'(!reset && m_resp_due && m_resp_mem));
      check_val("if_resp_data", if_resp_data, m_if_data);
      if (!reset && m_resp_due && m_resp_mem && m_resp_load)
        check_val("mem_resp_data", mem_resp_data, m_mem_data);
      if (!reset && m_resp_due) begin
        n_txn++;
        $display("txn %0d cycle=%0d port=%s data=%h", n_txn, cyc,
                 m_resp_mem ? (m_resp_load ? "mem-load" : "mem-store") : "fetch",
                 m_resp_mem ? m_mem_data : m_if_data);
      end

      if (reset) begin
        model_reset();
      end else begin
        m_resp_due = 0;
        if (g_mem || g_if) begin
          m_busy = 1; m_bus_acc = 0; m_owner_mem = g_mem; m_last_mem = g_mem;
          if (g_mem) begin
            x_wr = mem_w; x_addr = mem_a; x_wdata = mem_d; x_wstrb = mem_s; mem_pend = 0;
          end else begin
            x_wr = 0; x_addr = if_a; x_wdata = '0; x_wstrb = '0; if_pend = 0;
          end
        end else if (m_busy && !m_bus_acc && bus_req_ready) begin
          m_bus_acc = 1; resp_wait = $urandom_range(0, 3);
        end else if (m_busy && m_bus_acc && bus_resp_valid) begin
          m_busy = 0; m_resp_due = 1; m_resp_mem = m_owner_mem; m_resp_load = !x_wr;
          if (m_owner_mem) m_mem_data = bus_resp_data;
          else m_if_data = bus_resp_data;
        end
      end
    end

    check_val("txn_count_nonzero", 64'(n_txn > 0), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
